// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM encoding and size defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index register width for n slices; never below 1 bit so a single-slice
  // build still has a legal vector.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub16_if.sv
// Operand/result bundle between a requester and the serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: none; requester watches busy/done before issuing start.
// Ports: master drives start/A/B/Bin and sees busy/done/D/Bo/V; slave is the reverse.
interface serial_sub16_if import sub_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bo;
  logic             V;

  modport master (output start, A, B, Bin, input busy, done, D, Bo, V);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bo, V);

endinterface

// File: rtl/cla_slice.sv
// SLICE-bit carry-look-ahead adder: Sum = X + Y + Ci, Cout = carry out of the top bit.
// Latency: combinational.
// Backpressure: none.
// Ports: X, Y (SLICE bits), Ci in; Sum (SLICE bits), Cout out.
module cla_slice import sub_pkg::*; #(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] X,
  input  logic [SLICE-1:0] Y,
  input  logic             Ci,
  output logic [SLICE-1:0] Sum,
  output logic             Cout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             acc;
  logic             pp;

  assign g = X & Y;
  assign p = X ^ Y;

  // Each carry is the flattened sum-of-products of generates and propagates,
  // so no carry depends on a lower computed carry (true look-ahead form).
  always_comb begin
    c   = '0;
    acc = 1'b0;
    pp  = 1'b0;
    c[0] = Ci;
    for (int i = 0; i < SLICE; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc    = acc | (pp & Ci);
      c[i+1] = acc;
    end
  end

  assign Sum  = p ^ c[SLICE-1:0];
  assign Cout = c[SLICE];

endmodule

// File: rtl/serial_sub16.sv
// Serial subtractor D = A - B - Bin, one SLICE-bit slice per cycle through a shared CLA.
// Latency: WIDTH/SLICE cycles from accepted start to done (4 at defaults).
// Backpressure: start is ignored while busy; accepted in IDLE or DONE (incl. the done cycle).
// Ports: clk, rst (async, active high); bus (slave modport) carries start/A/B/Bin in, busy/done/D/Bo/V out.
module serial_sub16 import sub_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub16_if.slave bus
);

  localparam int                NSLICE = WIDTH / SLICE;
  localparam int                IDXW   = idx_bits(NSLICE);
  localparam logic [IDXW-1:0]   LAST   = IDXW'(NSLICE - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  d_q;
  logic              bo_q;
  logic              v_q;

  logic [SLICE-1:0]  a_sl_d;
  logic [SLICE-1:0]  nb_sl_d;
  logic [SLICE-1:0]  sum_d;
  logic              cout_d;

  // Subtraction as A + ~B + ~Bin: the carry chain holds the inverted borrow.
  assign a_sl_d  = a_q[idx_q*SLICE +: SLICE];
  assign nb_sl_d = ~b_q[idx_q*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_cla (
    .X    (a_sl_d),
    .Y    (nb_sl_d),
    .Ci   (carry_q),
    .Sum  (sum_d),
    .Cout (cout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= ~bus.Bin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          d_q[idx_q*SLICE +: SLICE] <= sum_d;
          carry_q <= cout_d;
          if (idx_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bo_q    <= ~cout_d;
            // Overflow when operand signs differ and the result sign differs from A.
            v_q     <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum_d[SLICE-1] ^ a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bo   = bo_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Directed bench for serial_sub16: hand-computed vectors, latency, back-to-back and reset.
module tb_serial_sub16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  serial_sub16_if #(.WIDTH(16)) bus ();

  serial_sub16 #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  // Called right after the accepting edge: done must rise exactly 4 edges later.
  task automatic expect_result(input string tag, input logic [15:0] d, input logic bo, input logic v);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, " done0"}, {31'd0, bus.done}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick;
      check({tag, " early_done"}, {31'd0, bus.done}, 32'd0);
    end
    tick;
    check({tag, " done"}, {31'd0, bus.done}, 32'd1);
    check({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " D"}, {16'd0, bus.D}, {16'd0, d});
    check({tag, " Bo"}, {31'd0, bus.Bo}, {31'd0, bo});
    check({tag, " V"}, {31'd0, bus.V}, {31'd0, v});
  endtask

  task automatic expect_hold(input string tag, input logic [15:0] d);
    tick;
    check({tag, " done_drop"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " D_hold"}, {16'd0, bus.D}, {16'd0, d});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    #12;
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst D",    {16'd0, bus.D},    32'd0);
    check("rst Bo",   {31'd0, bus.Bo},   32'd0);
    check("rst V",    {31'd0, bus.V},    32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Basic vectors.
    start_op(16'h0005, 16'h0003, 1'b0);
    expect_result("v1", 16'h0002, 1'b0, 1'b0);
    expect_hold("v1", 16'h0002);

    start_op(16'h0000, 16'h0001, 1'b0);
    expect_result("v2", 16'hFFFF, 1'b1, 1'b0);
    expect_hold("v2", 16'hFFFF);

    start_op(16'h8000, 16'h0001, 1'b0);
    expect_result("v3", 16'h7FFF, 1'b0, 1'b1);
    expect_hold("v3", 16'h7FFF);

    start_op(16'h1234, 16'h1234, 1'b1);
    expect_result("v4", 16'hFFFF, 1'b1, 1'b0);
    expect_hold("v4", 16'hFFFF);

    // start during RUN is ignored; the first result completes unchanged.
    start_op(16'h0100, 16'h0001, 1'b0);
    check("ign busy", {31'd0, bus.busy}, 32'd1);
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0000;
    bus.Bin   = 1'b1;
    bus.start = 1'b1;
    tick;
    check("ign done1", {31'd0, bus.done}, 32'd0);
    tick;
    check("ign done2", {31'd0, bus.done}, 32'd0);
    tick;
    check("ign done3", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    tick;
    check("ign done", {31'd0, bus.done}, 32'd1);
    check("ign D",    {16'd0, bus.D},    32'h0000_00FF);
    check("ign Bo",   {31'd0, bus.Bo},   32'd0);
    check("ign V",    {31'd0, bus.V},    32'd0);

    // Back-to-back: start while done is high.
    start_op(16'h7FFF, 16'hFFFF, 1'b0);
    expect_result("b2b", 16'h8000, 1'b1, 1'b1);
    expect_hold("b2b", 16'h8000);

    // Reset two cycles into RUN abandons the operation.
    start_op(16'h1111, 16'h0001, 1'b0);
    tick;
    tick;
    check("mid busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst busy", {31'd0, bus.busy}, 32'd0);
    check("arst done", {31'd0, bus.done}, 32'd0);
    check("arst D",    {16'd0, bus.D},    32'd0);
    check("arst Bo",   {31'd0, bus.Bo},   32'd0);
    check("arst V",    {31'd0, bus.V},    32'd0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("no_done", {31'd0, bus.done}, 32'd0);
    end

    start_op(16'h00FF, 16'h000F, 1'b0);
    expect_result("post_rst", 16'h00F0, 1'b0, 1'b0);
    expect_hold("post_rst", 16'h00F0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter SLICE, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new subtraction; sampled on rising edge of clk.
REQ-006 A  input  WIDTH  minuend; sampled when start is accepted.
REQ-007 B  input  WIDTH  subtrahend; sampled when start is accepted.
REQ-008 Bin  input  1  borrow-in; sampled when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-012 Bo  output  1  borrow-out; 1 when unsigned A < B + Bin.
REQ-013 V  output  1  two's-complement signed overflow of the subtraction.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; reset state is IDLE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: it latches A, B and Bin, clears the slice index to 0, sets the internal carry to ~Bin, and enters RUN.
REQ-016 In RUN, start SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-017 Each RUN cycle k (k = 0..WIDTH/SLICE-1) SHALL compute D slice k as A slice + ~B slice + carry, using one SLICE-bit carry-look-ahead add.
REQ-018 The carry-out of slice k SHALL be registered as the carry-in of slice k+1.
REQ-019 After the last slice, the FSM SHALL enter DONE; latency from accepted start to done high is exactly WIDTH/SLICE cycles (4 at default).
REQ-020 done SHALL be high for exactly the first cycle in DONE; the FSM then remains in DONE with done low until the next accepted start.
REQ-021 busy SHALL be 1 exactly when the state is RUN.
REQ-022 Bo SHALL equal the inverse of the final slice carry-out.
REQ-023 V SHALL equal (A[msb] XOR B[msb]) AND (D[msb] XOR A[msb]), using the latched operands.
REQ-024 D, Bo and V SHALL hold their last valid values from done until the next accepted start.
REQ-025 D, Bo and V are not valid during RUN; partial D slices MAY be visible.
REQ-026 start asserted in the same cycle done is high SHALL be accepted, as a back-to-back operation.

Reset
REQ-027 rst=1 SHALL immediately force the state to IDLE and busy, done, D, Bo, V, the carry and the slice index to 0, independent of clk.
REQ-028 Reset during RUN SHALL abandon the operation; done SHALL NOT pulse for it.
REQ-029 After rst is released, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-030 A shared package sub_pkg SHALL hold the FSM state encodings and the WIDTH and SLICE defaults.
REQ-031 The SLICE-bit carry-look-ahead adder SHALL be a separate sub-module, cla_slice: inputs X, Y, Ci; outputs Sum, Cout; purely combinational.
REQ-032 serial_sub16 SHALL instantiate exactly one cla_slice, time-multiplexed across slices.

Verification
REQ-033 A=0x0005, B=0x0003, Bin=0 -> D=0x0002, Bo=0, V=0; done high exactly 4 cycles after start.
REQ-034 A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bo=1, V=0.
REQ-035 A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bo=0, V=1.
REQ-036 A=0x1234, B=0x1234, Bin=1 -> D=0xFFFF, Bo=1, V=0.
REQ-037 start re-asserted with new operands during RUN -> ignored; the first result completes unchanged; then back-to-back start in the done cycle -> second result 4 cycles later.
REQ-038 rst pulsed 2 cycles into RUN -> outputs 0 at once, no done pulse; a later A=0x00FF, B=0x000F, Bin=0 -> D=0x00F0, Bo=0, V=0.
